// File: rtl/fpmul_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fpmul_pkg
// Brief    : IEEE-754 single-precision field positions and status-flag indices.
// Revision : 1.0
// ============================================================================
package fpmul_pkg;

    localparam int EXP_MSB           = 30;
    localparam int EXP_LSB           = 23;
    localparam int FRAC_MSB          = 22;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_DENORM = 1;
    localparam int FLAG_INF    = 2;
    localparam int FLAG_NAN    = 3;
    localparam int FLAG_W      = 4;

endpackage : fpmul_pkg
`default_nettype wire

// File: rtl/fpmul_result_fifo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fpmul_result_fifo_if
// Brief    : Producer and consumer valid/ready streams of the result FIFO.
// Revision : 1.0
// ============================================================================
interface fpmul_result_fifo_if
    import fpmul_pkg::*;
#(
    parameter int DW = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [FLAG_W-1:0] out_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface : fpmul_result_fifo_if
`default_nettype wire

// File: rtl/fp32_classify.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fp32_classify
// Brief    : Combinational {nan, inf, denorm, zero} classifier for binary32.
// Revision : 1.0
// ============================================================================
module fp32_classify
    import fpmul_pkg::*;
(
    input  wire logic [31:0]       i_value,
    output logic      [FLAG_W-1:0] o_flags
);
    logic [7:0]        w_exp;
    logic [FRAC_MSB:0] w_frac;
    logic              w_frac_nz;
    logic              w_sign_unused;

    assign w_exp         = i_value[EXP_MSB:EXP_LSB];
    assign w_frac        = i_value[FRAC_MSB:0];
    assign w_frac_nz     = |w_frac;
    assign w_sign_unused = i_value[31];

    always_comb begin
        o_flags              = '0;
        o_flags[FLAG_ZERO]   = (w_exp == 8'h00)        && !w_frac_nz;
        o_flags[FLAG_DENORM] = (w_exp == 8'h00)        &&  w_frac_nz;
        o_flags[FLAG_INF]    = (w_exp == EXP_ALL_ONES) && !w_frac_nz;
        o_flags[FLAG_NAN]    = (w_exp == EXP_ALL_ONES) &&  w_frac_nz;
    end
endmodule : fp32_classify
`default_nettype wire

// File: rtl/fpmul_result_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fpmul_result_fifo
// Brief    : First-word-fall-through FIFO for multiplier results with flags
//            classified at push time and a delivered-result counter.
// Revision : 1.0
// ============================================================================
module fpmul_result_fifo
    import fpmul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int CNT_W = 16
)(
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     clr,
    fpmul_result_fifo_if.slave            bus,
    output logic      [$clog2(DEPTH):0]   level,
    output logic      [CNT_W-1:0]         result_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = DW + FLAG_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   result_cnt_q, result_cnt_d;

    logic [FLAG_W-1:0]  w_in_flags;
    logic [ENTRY_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;

    fp32_classify u_classify (
        .i_value (bus.in_data),
        .o_flags (w_in_flags)
    );

    // Handshake is derived from registered occupancy only: no full-bypass.
    assign bus.in_ready  = (level_q != LVL_W'(DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign w_push        = bus.in_valid  && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    assign w_head        = mem_q[rd_ptr_q];
    assign bus.out_data  = bus.out_valid ? w_head[DW-1:0]       : '0;
    assign bus.out_flags = bus.out_valid ? w_head[ENTRY_W-1:DW] : '0;
    assign level         = level_q;
    assign result_cnt    = result_cnt_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        result_cnt_d = result_cnt_q;
        if (clr) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            result_cnt_d = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop) begin
                rd_ptr_d     = rd_ptr_q + PTR_W'(1);
                result_cnt_d = result_cnt_q + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            result_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            result_cnt_q <= result_cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            mem_q[wr_ptr_q] <= {w_in_flags, bus.in_data};
        end
    end
endmodule : fpmul_result_fifo
`default_nettype wire

// File: tb/tb_fpmul_result_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fpmul_result_fifo
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fpmul_result_fifo;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CNT_W = 16;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
    } vec_t;

    logic clk;
    logic rst_n;
    logic clr;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       result_cnt;

    fpmul_result_fifo_if #(.DW(DW)) bus ();

    fpmul_result_fifo #(.DEPTH(DEPTH), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .level      (level),
        .result_cnt (result_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        clr           = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    // Classification from the IEEE-754 category definitions.
    function automatic logic [3:0] ref_flags(input logic [31:0] v);
        int unsigned biased_exp;
        bit          has_frac;
        biased_exp = int'(v[30:23]);
        has_frac   = (v[22:0] != 23'd0);
        if (biased_exp == 255) return has_frac ? 4'b1000 : 4'b0100;
        if (biased_exp == 0)   return has_frac ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    vec_t tbl [12];
    logic [35:0] model_q [$];
    int unsigned model_cnt;
    logic [31:0] rd;
    bit          exp_push, exp_pop;

    initial begin
        tbl[0]  = '{32'h00000000, 4'b0001};
        tbl[1]  = '{32'h00400000, 4'b0010};
        tbl[2]  = '{32'h7F800000, 4'b0100};
        tbl[3]  = '{32'h7FC00000, 4'b1000};
        tbl[4]  = '{32'h80000000, 4'b0001};
        tbl[5]  = '{32'hFF800000, 4'b0100};
        tbl[6]  = '{32'h00000001, 4'b0010};
        tbl[7]  = '{32'h7F800001, 4'b1000};
        tbl[8]  = '{32'h807FFFFF, 4'b0010};
        tbl[9]  = '{32'h00800000, 4'b0000};
        tbl[10] = '{32'h7F7FFFFF, 4'b0000};
        tbl[11] = '{32'hC0490FDB, 4'b0000};

        // Power-on reset
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_level",     level, 0);
        chk("rst_cnt",       result_cnt, 0);
        chk("rst_out_data",  bus.out_data, 0);
        chk("rst_out_flags", bus.out_flags, 0);

        // Single push, then one pop
        bus.out_ready = 1'b0;
        push_one(32'h3F800000);
        chk("single_valid", bus.out_valid, 1);
        chk("single_data",  bus.out_data, 32'h3F800000);
        chk("single_flags", bus.out_flags, 0);
        chk("single_level", level, 1);
        pop_one();
        chk("single_valid_after_pop", bus.out_valid, 0);
        chk("single_cnt", result_cnt, 1);

        // Table: each vector through the FIFO alone
        for (int i = 0; i < 12; i++) begin
            push_one(tbl[i].data);
            chk($sformatf("tbl%0d_data", i),  bus.out_data,  tbl[i].data);
            chk($sformatf("tbl%0d_flags", i), bus.out_flags, tbl[i].flags);
            pop_one();
        end
        chk("tbl_cnt", result_cnt, 13);

        // Fill with backpressure, 5th value held off, drain with full-pop
        for (int i = 0; i < 4; i++) push_one(tbl[i].data);
        chk("full_level", level, 4);
        chk("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40000000;
        repeat (2) step();
        chk("full_hold_level", level, 4);
        chk("full_hold_head", bus.out_data, tbl[0].data);
        chk("drain0_data",  bus.out_data,  tbl[0].data);
        chk("drain0_flags", bus.out_flags, tbl[0].flags);
        bus.out_ready = 1'b1;
        step();
        chk("full_pop_only_level", level, 3);
        chk("drain1_data",  bus.out_data,  tbl[1].data);
        chk("drain1_flags", bus.out_flags, tbl[1].flags);
        step();
        bus.in_valid = 1'b0;
        chk("held_accept_level", level, 3);
        for (int i = 2; i < 4; i++) begin
            chk($sformatf("drain%0d_data", i),  bus.out_data,  tbl[i].data);
            chk($sformatf("drain%0d_flags", i), bus.out_flags, tbl[i].flags);
            step();
        end
        chk("drain_held_data", bus.out_data, 32'h40000000);
        step();
        bus.out_ready = 1'b0;
        chk("drain_empty", bus.out_valid, 0);
        chk("drain_cnt", result_cnt, 18);

        // Simultaneous push and pop at level 2
        push_one(32'h11111111);
        push_one(32'h22222222);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h33333333;
        bus.out_ready = 1'b1;
        step();
        idle_inputs();
        chk("pushpop_level", level, 2);
        chk("pushpop_head", bus.out_data, 32'h22222222);
        pop_one();
        chk("pushpop_next", bus.out_data, 32'h33333333);
        pop_one();
        chk("pushpop_cnt", result_cnt, 21);

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) push_one(32'h3F000000 + i);
        chk("pre_rst_level", level, 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_cnt", result_cnt, 0);
        chk("async_rst_data", bus.out_data, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_valid", bus.out_valid, 0);

        // clr overrides simultaneous push and pop
        for (int i = 0; i < 4; i++) push_one(32'h40400000 + i);
        pop_one();
        chk("pre_clr_level", level, 3);
        chk("pre_clr_cnt", result_cnt, 1);
        clr           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        step();
        idle_inputs();
        chk("clr_level", level, 0);
        chk("clr_valid", bus.out_valid, 0);
        chk("clr_cnt", result_cnt, 0);
        step();
        chk("clr_dropped", bus.out_valid, 0);

        // Randomized traffic against a queue model
        model_q.delete();
        model_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            rd = $urandom;
            case ($urandom_range(0, 3))
                0: rd[30:23] = 8'h00;
                1: rd[30:23] = 8'hFF;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) rd[22:0] = '0;
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = rd;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 149) == 0);

            chk("rnd_out_valid", bus.out_valid, model_q.size() != 0);
            chk("rnd_in_ready",  bus.in_ready,  model_q.size() != DEPTH);
            chk("rnd_level",     level,         model_q.size());
            chk("rnd_cnt",       result_cnt,    model_cnt);
            chk("rnd_data",  bus.out_data,  (model_q.size() != 0) ? model_q[0][31:0]  : 32'h0);
            chk("rnd_flags", bus.out_flags, (model_q.size() != 0) ? model_q[0][35:32] : 4'h0);

            exp_push = bus.in_valid  && (model_q.size() < DEPTH);
            exp_pop  = bus.out_ready && (model_q.size() > 0);
            step();
            if (clr) begin
                model_q.delete();
                model_cnt = 0;
            end else begin
                if (exp_pop) begin
                    void'(model_q.pop_front());
                    model_cnt = (model_cnt + 1) % (1 << CNT_W);
                end
                if (exp_push) model_q.push_back({ref_flags(rd), rd});
            end
        end
        idle_inputs();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("rnd_final_clr_level", level, 0);

        // Stream 2^CNT_W+3 values; counter wraps and order survives pointer wrap
        begin
            int unsigned total;
            int unsigned pushed;
            int unsigned popped;
            int unsigned order_bad;
            int unsigned budget;
            total     = (1 << CNT_W) + 3;
            pushed    = 0;
            popped    = 0;
            order_bad = 0;
            budget    = 0;
            bus.out_ready = 1'b1;
            while (popped < total && budget < total + 50) begin
                bus.in_valid = (pushed < total);
                bus.in_data  = pushed;
                if (bus.out_valid) begin
                    if (bus.out_data !== popped) order_bad++;
                    popped++;
                end
                if (bus.in_valid && bus.in_ready) pushed++;
                step();
                budget++;
            end
            idle_inputs();
            chk("wrap_all_popped", popped, total);
            chk("wrap_order_errors", order_bad, 0);
            chk("wrap_cnt", result_cnt, 3);
            chk("wrap_level", level, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule : tb_fpmul_result_fifo
`default_nettype wire
